// File: rtl/dff_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : dff_monitor
//  Purpose  : Watches the pins of a preset/clear D flip-flop under test and
//             scores a run of NUM_SAMPLES cycles against an internal ideal
//             model of the same flip-flop.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk            in   single clock, all state updates on the rising edge
//    CLR            in   synchronous active-high reset
//    start          in   begin a run (sampled only in IDLE or DONE)
//    mon_pre        in   observed preset of the flip-flop (active-high)
//    mon_clr        in   observed clear of the flip-flop (active-high)
//    mon_d          in   observed D of the flip-flop
//    mon_q          in   observed Q of the flip-flop
//    mon_qbar       in   observed Qbar of the flip-flop
//    busy           out  high in ARM and RUN
//    done           out  high in DONE
//    pass           out  high in DONE when err_cnt is zero
//    err_cnt        out  mismatching cycles in the current/last run (saturating)
//    inv_cnt        out  skipped cycles after a pre+clr hold (saturating)
//    first_err_idx  out  sample index of the first mismatch
//    first_err_vld  out  first_err_idx is valid
// ============================================================================
module dff_monitor #(
    parameter int NUM_SAMPLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             CLR,
    input  logic             start,
    input  logic             mon_pre,
    input  logic             mon_clr,
    input  logic             mon_d,
    input  logic             mon_q,
    input  logic             mon_qbar,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] inv_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_vld
);

    // The sample index is kept at least 8 bits wide so that any legal
    // NUM_SAMPLES (up to 255) terminates the run even with a narrow CNT_W;
    // the reported first_err_idx is the low CNT_W bits of it.
    localparam int                IDX_W      = (CNT_W > 8) ? CNT_W : 8;
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [IDX_W-1:0]  C_IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic             r_exp_q;
    logic             r_skip;
    logic [IDX_W-1:0] r_sample_idx;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_inv_cnt;
    logic [CNT_W-1:0] r_first_err_idx;
    logic             r_first_err_vld;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_exp_q_nxt;
    logic             w_skip_nxt;
    logic [IDX_W-1:0] w_sample_idx_nxt;
    logic [CNT_W-1:0] w_err_cnt_nxt;
    logic [CNT_W-1:0] w_inv_cnt_nxt;
    logic [CNT_W-1:0] w_first_err_idx_nxt;
    logic             w_first_err_vld_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;

    logic             w_hold;
    logic             w_exp_upd;
    logic             w_mismatch;
    logic             w_arm_entry;

    // Ideal flip-flop behaviour: pre and clr together is treated as an
    // illegal combination in which the model simply keeps its last value.
    assign w_hold      = mon_pre & mon_clr;
    assign w_exp_upd   = w_hold  ? r_exp_q :
                         mon_clr ? 1'b0    :
                         mon_pre ? 1'b1    : mon_d;
    assign w_mismatch  = (mon_q != r_exp_q) | (mon_qbar == mon_q);
    assign w_arm_entry = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

    // ------------------------------------------------------------------
    // State register and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin : p_state_reg
        if (CLR) begin
            r_state         <= S_IDLE;
            r_exp_q         <= 1'b0;
            r_skip          <= 1'b0;
            r_sample_idx    <= '0;
            r_err_cnt       <= '0;
            r_inv_cnt       <= '0;
            r_first_err_idx <= '0;
            r_first_err_vld <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_exp_q         <= w_exp_q_nxt;
            r_skip          <= w_skip_nxt;
            r_sample_idx    <= w_sample_idx_nxt;
            r_err_cnt       <= w_err_cnt_nxt;
            r_inv_cnt       <= w_inv_cnt_nxt;
            r_first_err_idx <= w_first_err_idx_nxt;
            r_first_err_vld <= w_first_err_vld_nxt;
            r_busy          <= w_busy_nxt;
            r_done          <= w_done_nxt;
            r_pass          <= w_pass_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : p_next_state
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ARM;
            S_ARM:   w_state_nxt = S_RUN;
            S_RUN:   if (r_sample_idx == C_LAST_IDX) w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_ARM;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: expected-Q model, sample index and score counters
    // ------------------------------------------------------------------
    always_comb begin : p_datapath
        w_exp_q_nxt         = r_exp_q;
        w_skip_nxt          = r_skip;
        w_sample_idx_nxt    = r_sample_idx;
        w_err_cnt_nxt       = r_err_cnt;
        w_inv_cnt_nxt       = r_inv_cnt;
        w_first_err_idx_nxt = r_first_err_idx;
        w_first_err_vld_nxt = r_first_err_vld;

        if (w_arm_entry) begin
            // Clearing on the edge into ARM makes the counters read zero
            // for the whole ARM cycle and discards the previous result.
            w_sample_idx_nxt    = '0;
            w_err_cnt_nxt       = '0;
            w_inv_cnt_nxt       = '0;
            w_first_err_idx_nxt = '0;
            w_first_err_vld_nxt = 1'b0;
        end else if (r_state == S_ARM) begin
            w_exp_q_nxt      = w_exp_upd;
            w_skip_nxt       = w_hold;
            w_sample_idx_nxt = '0;
        end else if (r_state == S_RUN) begin
            // A cycle following a pre+clr hold has no defined expectation,
            // so it is counted as invalid instead of being compared.
            if (r_skip) begin
                if (r_inv_cnt != C_CNT_MAX) begin
                    w_inv_cnt_nxt = r_inv_cnt + C_CNT_ONE;
                end
            end else if (w_mismatch) begin
                if (r_err_cnt != C_CNT_MAX) begin
                    w_err_cnt_nxt = r_err_cnt + C_CNT_ONE;
                end
                if (!r_first_err_vld) begin
                    w_first_err_idx_nxt = r_sample_idx[CNT_W-1:0];
                    w_first_err_vld_nxt = 1'b1;
                end
            end
            w_exp_q_nxt      = w_exp_upd;
            w_skip_nxt       = w_hold;
            w_sample_idx_nxt = r_sample_idx + C_IDX_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (from next state, so the registered flags line up
    // with the state they describe)
    // ------------------------------------------------------------------
    always_comb begin : p_outputs
        w_busy_nxt = (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_pass_nxt = (w_state_nxt == S_DONE) && (w_err_cnt_nxt == '0);
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign inv_cnt       = r_inv_cnt;
    assign first_err_idx = r_first_err_idx;
    assign first_err_vld = r_first_err_vld;

endmodule
`default_nettype wire

// File: tb/tb_dff_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_monitor
//  Purpose  : Self-checking bench for dff_monitor. Stimulus for each run is
//             prepared as per-cycle arrays from an ideal flip-flop with
//             planted faults; expected scores come from a sample-by-sample
//             reference scoring routine.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dff_monitor;

    localparam int N_A = 16;
    localparam int W_A = 8;
    localparam int N_B = 20;
    localparam int W_B = 4;
    localparam int MAXL = 32;

    logic clk = 1'b0;
    logic CLR, start, mon_pre, mon_clr, mon_d, mon_q, mon_qbar;

    logic           a_busy, a_done, a_pass, a_vld;
    logic [W_A-1:0] a_err, a_inv, a_idx;
    logic           b_busy, b_done, b_pass, b_vld;
    logic [W_B-1:0] b_err, b_inv, b_idx;

    bit s_pre [MAXL];
    bit s_clr [MAXL];
    bit s_d   [MAXL];
    bit s_q   [MAXL];
    bit s_qb  [MAXL];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dff_monitor #(.NUM_SAMPLES(N_A), .CNT_W(W_A)) u_dut_a (
        .Clk(clk), .CLR(CLR), .start(start),
        .mon_pre(mon_pre), .mon_clr(mon_clr), .mon_d(mon_d),
        .mon_q(mon_q), .mon_qbar(mon_qbar),
        .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_cnt(a_err), .inv_cnt(a_inv),
        .first_err_idx(a_idx), .first_err_vld(a_vld)
    );

    dff_monitor #(.NUM_SAMPLES(N_B), .CNT_W(W_B)) u_dut_b (
        .Clk(clk), .CLR(CLR), .start(start),
        .mon_pre(mon_pre), .mon_clr(mon_clr), .mon_d(mon_d),
        .mon_q(mon_q), .mon_qbar(mon_qbar),
        .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_cnt(b_err), .inv_cnt(b_inv),
        .first_err_idx(b_idx), .first_err_vld(b_vld)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit ff_next(bit q, bit p, bit c, bit d);
        if (p && c) return q;
        if (c)      return 1'b0;
        if (p)      return 1'b1;
        return d;
    endfunction

    // mode 0: ideal, D toggles        mode 1: mon_q inverted at sample 5
    // mode 2: pre+clr held 3 cycles   mode 3: qbar tied to q
    // mode 4: random controls and random pin faults
    task automatic build(input int mode, input int len);
        bit q;
        q = 1'($urandom_range(0, 1));
        for (int k = 0; k <= len; k++) begin
            s_pre[k] = 1'b0;
            s_clr[k] = 1'b0;
            s_d[k]   = k[0];
            if (mode == 2 && k >= 6 && k <= 8) begin
                s_pre[k] = 1'b1;
                s_clr[k] = 1'b1;
            end
            if (mode == 4) begin
                s_d[k]   = 1'($urandom_range(0, 1));
                s_pre[k] = ($urandom_range(0, 4) == 0);
                s_clr[k] = ($urandom_range(0, 4) == 0);
                if (k == 0) s_clr[k] = s_clr[k] & ~s_pre[k];
            end
            s_q[k]  = q;
            s_qb[k] = ~q;
            if (mode == 1 && k == 6) s_q[k] = ~q;
            if (mode == 3) s_qb[k] = s_q[k];
            if (mode == 4 && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) s_q[k] = ~q;
                else                           s_qb[k] = q;
            end
            q = ff_next(q, s_pre[k], s_clr[k], s_d[k]);
        end
    endtask

    // Scores a run of n samples directly from the stimulus arrays.
    // Entry 0 is what the monitor sees while arming; sample s sees entry s+1.
    task automatic model(input int n, input int w, output int e, output int v,
                         output int fi, output int fv);
        int  mx;
        bit  ex, skip;
        mx = (1 << w) - 1;
        e = 0; v = 0; fi = 0; fv = 0;
        ex   = ff_next(1'b0, s_pre[0], s_clr[0], s_d[0]);
        skip = s_pre[0] & s_clr[0];
        for (int s = 0; s < n; s++) begin
            if (skip) begin
                if (v < mx) v++;
            end else if (s_q[s+1] != ex || s_qb[s+1] == s_q[s+1]) begin
                if (e < mx) e++;
                if (fv == 0) begin
                    fv = 1;
                    fi = s % (1 << w);
                end
            end
            ex   = ff_next(ex, s_pre[s+1], s_clr[s+1], s_d[s+1]);
            skip = s_pre[s+1] & s_clr[s+1];
        end
    endtask

    task automatic drive(input int k);
        mon_pre  = s_pre[k];
        mon_clr  = s_clr[k];
        mon_d    = s_d[k];
        mon_q    = s_q[k];
        mon_qbar = s_qb[k];
    endtask

    task automatic idle_pins();
        mon_pre = 0; mon_clr = 0; mon_d = 0; mon_q = 0; mon_qbar = 1;
    endtask

    // Start pulse, then len+1 cycles of stimulus (ARM + len samples).
    // Returns with the next negedge being the first one after the last
    // sample edge. If clr_at >= 0, CLR is asserted with entry clr_at.
    task automatic run(input int len, input bit hold_start, input int clr_at,
                       output int busy_cnt);
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        idle_pins();
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            if (a_busy) busy_cnt++;
            start = hold_start;
            drive(k);
            if (k == clr_at) begin
                CLR = 1'b1;
                return;
            end
        end
        @(negedge clk);
        idle_pins();
    endtask

    task automatic check_a(input string tag);
        int e, v, fi, fv;
        model(N_A, W_A, e, v, fi, fv);
        chk({tag, ".done"},  32'(a_done), 1);
        chk({tag, ".busy"},  32'(a_busy), 0);
        chk({tag, ".pass"},  32'(a_pass), (e == 0) ? 1 : 0);
        chk({tag, ".err"},   32'(a_err),  e);
        chk({tag, ".inv"},   32'(a_inv),  v);
        chk({tag, ".vld"},   32'(a_vld),  fv);
        chk({tag, ".idx"},   32'(a_idx),  fi);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"}, 32'(a_busy), 0);
        chk({tag, ".done"}, 32'(a_done), 0);
        chk({tag, ".pass"}, 32'(a_pass), 0);
        chk({tag, ".err"},  32'(a_err),  0);
        chk({tag, ".inv"},  32'(a_inv),  0);
        chk({tag, ".idx"},  32'(a_idx),  0);
        chk({tag, ".vld"},  32'(a_vld),  0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        CLR = 1'b1;
        start = 1'b0;
        idle_pins();
        @(negedge clk);
        @(negedge clk);
        CLR = 1'b0;
    endtask

    initial begin
        int bc;
        CLR = 1'b1;
        start = 1'b0;
        idle_pins();
        do_reset();
        check_zero("reset");

        // Ideal flip-flop, D toggling
        build(0, N_A);
        run(N_A, 1'b0, -1, bc);
        chk("ideal.busy_cycles", bc, 17);
        check_a("ideal");
        chk("ideal.pass_const", 32'(a_pass), 1);

        // Single inverted Q at sample 5
        do_reset();
        build(1, N_A);
        run(N_A, 1'b0, -1, bc);
        check_a("qflip");
        chk("qflip.err_const", 32'(a_err), 1);
        chk("qflip.idx_const", 32'(a_idx), 5);
        @(negedge clk);
        chk("qflip.hold_done", 32'(a_done), 1);
        chk("qflip.hold_err",  32'(a_err), 1);

        // Three cycles of pre+clr mid-run
        do_reset();
        build(2, N_A);
        run(N_A, 1'b0, -1, bc);
        check_a("hold3");
        chk("hold3.inv_const", 32'(a_inv), 3);

        // Qbar tied to Q: every sample fails; narrow instance saturates
        do_reset();
        build(3, N_B);
        run(N_B, 1'b0, -1, bc);
        check_a("qbq");
        chk("qbq.err_const", 32'(a_err), 16);
        chk("qbq.idx_const", 32'(a_idx), 0);
        chk("qbq.b_done", 32'(b_done), 1);
        chk("qbq.b_err",  32'(b_err), 15);
        chk("qbq.b_pass", 32'(b_pass), 0);
        chk("qbq.b_idx",  32'(b_idx), 0);

        // Reset in the middle of a failing run, then a clean fresh run
        do_reset();
        build(3, N_A);
        run(N_A, 1'b0, 8, bc);
        @(negedge clk);
        CLR = 1'b0;
        idle_pins();
        check_zero("midclr");
        build(4, N_A);
        run(N_A, 1'b0, -1, bc);
        chk("after_clr.busy_cycles", bc, 17);
        check_a("after_clr");

        // Start held high through the run and into DONE
        do_reset();
        build(3, N_A);
        run(N_A, 1'b1, -1, bc);
        chk("hold_start.busy_cycles", bc, 17);
        chk("hold_start.done", 32'(a_done), 1);
        chk("hold_start.err",  32'(a_err), 16);
        start = 1'b1;
        @(negedge clk);
        chk("hold_start.rearm_done", 32'(a_done), 0);
        chk("hold_start.rearm_busy", 32'(a_busy), 1);
        chk("hold_start.rearm_err",  32'(a_err), 0);
        chk("hold_start.rearm_vld",  32'(a_vld), 0);
        start = 1'b0;

        // Back-to-back random runs, each starting from DONE
        do_reset();
        for (int r = 0; r < 8; r++) begin
            build(4, N_A);
            run(N_A, 1'b0, -1, bc);
            chk($sformatf("rand%0d.busy_cycles", r), bc, 17);
            check_a($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
